// File: rtl/match_pkg.sv
// Shared state codes, winner encodings and finish-bus decode for the match sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNTDOWN  = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_MATCH_OVER = 3'd4,
    ST_PAUSED     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  localparam int FINISH_KO_BIT = 0;
  localparam int FINISH_P2_BIT = 1;

  localparam logic [1:0] WINS_SAT = 2'd3;

  // Higher score wins; a tie is a draw. Used for both health and win counts.
  function automatic winner_t compare_scores(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      return W_P1;
    else if (b > a) return W_P2;
    else            return W_DRAW;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: single-cycle tick at terminal count, clear restarts, hold freezes.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST) && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      if (tick) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: countdown, timed fight, KO/timeout judgement, best-of-N scoring.
// Optional pause feature enabled by defining PAUSE_MATCH_EN.
module match_controller
  import match_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 100_000_000,
  parameter int COUNTDOWN_SECS = 3,
  parameter int ROUND_SECS     = 60,
  parameter int HOLD_SECS      = 3,
  parameter int WINS_TO_MATCH  = 2,
  parameter int MAX_ROUNDS     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [1:0] finish,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       game_rst_n,
  output logic       inputs_enable,
  output logic [2:0] state,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [3:0] countdown,
  output logic [6:0] seconds_left,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  localparam logic [3:0] CD_INIT    = 4'(COUNTDOWN_SECS);
  localparam logic [6:0] ROUND_INIT = 7'(ROUND_SECS);
  localparam logic [6:0] HOLD_LAST  = 7'(HOLD_SECS - 1);
  localparam logic [1:0] WINS_GOAL  = 2'(WINS_TO_MATCH);
  localparam logic [2:0] ROUND_MAX  = 3'(MAX_ROUNDS);

  state_t      cur_state, nx_state;
  winner_t     rw_q, mw_q, rw_nx, mw_nx, end_winner;
  logic [2:0]  round_nx;
  logic [1:0]  p1w_nx, p2w_nx;
  logic [3:0]  cd_nx;
  logic [6:0]  secs_nx, hold_cnt, hold_nx;
  logic        start_q, start_rise, pause_rise;
  logic        do_end, do_begin, match_done;
  logic        tick, tick_clear, tick_hold, pause_pair;

  assign start_rise = start_btn && !start_q;

`ifdef PAUSE_MATCH_EN
  logic pause_q;
  assign pause_rise = pause_btn && !pause_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pause_q <= 1'b0;
    else        pause_q <= pause_btn;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_rise   = 1'b0;
`endif

  // Fight/pause toggling keeps the prescaler phase; every other state entry restarts it.
  assign pause_pair = ((cur_state == ST_FIGHT) && (nx_state == ST_PAUSED)) ||
                      ((cur_state == ST_PAUSED) && (nx_state == ST_FIGHT));
  assign tick_clear = (nx_state != cur_state) && !pause_pair;
  assign tick_hold  = (cur_state == ST_PAUSED);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .hold (tick_hold),
    .tick (tick)
  );

  assign match_done = (p1_wins >= WINS_GOAL) || (p2_wins >= WINS_GOAL) ||
                      (round_num >= ROUND_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= ST_IDLE;
    else        cur_state <= nx_state;
  end

  always_comb begin
    nx_state   = cur_state;
    round_nx   = round_num;
    p1w_nx     = p1_wins;
    p2w_nx     = p2_wins;
    cd_nx      = countdown;
    secs_nx    = seconds_left;
    hold_nx    = hold_cnt;
    rw_nx      = rw_q;
    mw_nx      = mw_q;
    do_end     = 1'b0;
    do_begin   = 1'b0;
    end_winner = W_NONE;

    case (cur_state)
      ST_IDLE, ST_MATCH_OVER: begin
        if (start_rise) do_begin = 1'b1;
      end

      ST_COUNTDOWN: begin
        if (tick) begin
          if (countdown <= 4'd1) begin
            nx_state = ST_FIGHT;
            secs_nx  = ROUND_INIT;
            cd_nx    = 4'd0;
          end else begin
            cd_nx = countdown - 4'd1;
          end
        end
      end

      // A KO outranks a timeout landing on the same cycle.
      ST_FIGHT: begin
        if (finish[FINISH_KO_BIT]) begin
          do_end     = 1'b1;
          end_winner = finish[FINISH_P2_BIT] ? W_P2 : W_P1;
        end else if (tick && (seconds_left <= 7'd1)) begin
          do_end     = 1'b1;
          secs_nx    = 7'd0;
          end_winner = compare_scores(p1_health, p2_health);
        end else begin
          if (tick)       secs_nx  = seconds_left - 7'd1;
          if (pause_rise) nx_state = ST_PAUSED;
        end
      end

`ifdef PAUSE_MATCH_EN
      ST_PAUSED: begin
        if (finish[FINISH_KO_BIT]) begin
          do_end     = 1'b1;
          end_winner = finish[FINISH_P2_BIT] ? W_P2 : W_P1;
        end else if (pause_rise) begin
          nx_state = ST_FIGHT;
        end
      end
`endif

      ST_ROUND_END: begin
        if (tick) begin
          if (hold_cnt >= HOLD_LAST) begin
            if (match_done) begin
              nx_state = ST_MATCH_OVER;
              mw_nx    = compare_scores({2'b00, p1_wins}, {2'b00, p2_wins});
            end else begin
              nx_state = ST_COUNTDOWN;
              round_nx = round_num + 3'd1;
              cd_nx    = CD_INIT;
            end
          end else begin
            hold_nx = hold_cnt + 7'd1;
          end
        end
      end

      default: nx_state = ST_IDLE;
    endcase

    if (do_end) begin
      nx_state = ST_ROUND_END;
      hold_nx  = 7'd0;
      rw_nx    = end_winner;
      if ((end_winner == W_P1) && (p1_wins != WINS_SAT)) p1w_nx = p1_wins + 2'd1;
      if ((end_winner == W_P2) && (p2_wins != WINS_SAT)) p2w_nx = p2_wins + 2'd1;
    end

    if (do_begin) begin
      nx_state = ST_COUNTDOWN;
      round_nx = 3'd1;
      p1w_nx   = 2'd0;
      p2w_nx   = 2'd0;
      rw_nx    = W_NONE;
      mw_nx    = W_NONE;
      cd_nx    = CD_INIT;
    end
  end

  // Core controls follow the state being entered so they change on the first cycle there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q       <= 1'b0;
      game_rst_n    <= 1'b0;
      inputs_enable <= 1'b0;
      round_num     <= 3'd0;
      p1_wins       <= 2'd0;
      p2_wins       <= 2'd0;
      countdown     <= CD_INIT;
      seconds_left  <= ROUND_INIT;
      hold_cnt      <= 7'd0;
      rw_q          <= W_NONE;
      mw_q          <= W_NONE;
    end else begin
      start_q       <= start_btn;
      game_rst_n    <= (nx_state == ST_FIGHT) || (nx_state == ST_ROUND_END) ||
                       (nx_state == ST_MATCH_OVER) || (nx_state == ST_PAUSED);
      inputs_enable <= (nx_state == ST_FIGHT);
      round_num     <= round_nx;
      p1_wins       <= p1w_nx;
      p2_wins       <= p2w_nx;
      countdown     <= cd_nx;
      seconds_left  <= secs_nx;
      hold_cnt      <= hold_nx;
      rw_q          <= rw_nx;
      mw_q          <= mw_nx;
    end
  end

  assign state        = cur_state;
  assign round_winner = rw_q;
  assign match_winner = mw_q;

endmodule

// File: tb/tb_match_controller.sv
// Table-driven bench for match_controller with small timing parameters.
`timescale 1ns/1ps
module tb_match_controller;

  localparam int DC = -1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [1:0] finish = 2'b00;
  logic [3:0] p1_health = 4'd15;
  logic [3:0] p2_health = 4'd15;
  logic       game_rst_n, inputs_enable;
  logic [2:0] state, round_num;
  logic [1:0] p1_wins, p2_wins, round_winner, match_winner;
  logic [3:0] countdown;
  logic [6:0] seconds_left;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       start;
    logic [1:0] fin;
    logic [3:0] h1;
    logic [3:0] h2;
    int         cycles;
    int         st, rnd, w1, w2, cd, sec, rw, mw, grst, ie;
  } vec_t;

  vec_t vecs[$];

  match_controller #(
    .TICKS_PER_SEC (4),
    .COUNTDOWN_SECS(3),
    .ROUND_SECS    (5),
    .HOLD_SECS     (2),
    .WINS_TO_MATCH (2),
    .MAX_ROUNDS    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .finish       (finish),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .game_rst_n   (game_rst_n),
    .inputs_enable(inputs_enable),
    .state        (state),
    .round_num    (round_num),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .countdown    (countdown),
    .seconds_left (seconds_left),
    .round_winner (round_winner),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [1:0] f, input logic [3:0] a,
                              input logic [3:0] b, input int n, input int st, input int rnd,
                              input int w1, input int w2, input int cd, input int sec,
                              input int rw, input int mw, input int grst, input int ie);
    vec_t v;
    v.start = s;  v.fin = f;   v.h1 = a;   v.h2 = b;   v.cycles = n;
    v.st = st;    v.rnd = rnd; v.w1 = w1;  v.w2 = w2;  v.cd = cd;
    v.sec = sec;  v.rw = rw;   v.mw = mw;  v.grst = grst; v.ie = ie;
    return v;
  endfunction

  task automatic check_field(input string name, input int idx, input int got, input int want);
    if (want >= 0) begin
      total++;
      if (got != want) begin
        bad++;
        $display("[TB] FAIL %s (step %0d): got %0d, expected %0d", name, idx, got, want);
      end
    end
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check_field("state",         idx, int'(state),         v.st);
    check_field("round_num",     idx, int'(round_num),     v.rnd);
    check_field("p1_wins",       idx, int'(p1_wins),       v.w1);
    check_field("p2_wins",       idx, int'(p2_wins),       v.w2);
    check_field("countdown",     idx, int'(countdown),     v.cd);
    check_field("seconds_left",  idx, int'(seconds_left),  v.sec);
    check_field("round_winner",  idx, int'(round_winner),  v.rw);
    check_field("match_winner",  idx, int'(match_winner),  v.mw);
    check_field("game_rst_n",    idx, int'(game_rst_n),    v.grst);
    check_field("inputs_enable", idx, int'(inputs_enable), v.ie);
  endtask

  task automatic apply_stimulus(input vec_t v);
    start_btn = v.start;
    finish    = v.fin;
    p1_health = v.h1;
    p2_health = v.h2;
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output(0, mk(0, 0, 15, 15, 0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 0));
    reset = 1'b1;

    // Match 1: P1 KO, P2 timeout on health, P2 KO beating a same-cycle timeout.
    vecs.push_back(mk(1, 0, 15, 15,  1, 1, 1, 0, 0,  3,  5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 15, 15,  4, 1, 1, 0, 0,  2,  5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 15, 15,  4, 1, 1, 0, 0,  1,  5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 15, 15,  3, 1, 1, 0, 0,  1,  5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 15, 15,  1, 2, 1, 0, 0, DC,  5, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 15, 15,  4, 2, 1, 0, 0, DC,  4, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 15, 15,  1, 3, 1, 1, 0, DC,  4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 15, 15,  7, 3, 1, 1, 0, DC,  4, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 15, 15,  1, 1, 2, 1, 0,  3, DC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 15, 15, 12, 2, 2, 1, 0, DC,  5, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0,  7,  9, 19, 2, 2, 1, 0, DC,  1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0,  7,  9,  1, 3, 2, 1, 1, DC,  0, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0,  7,  9,  8, 1, 3, 1, 1,  3, DC, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 15,  2, 12, 2, 3, 1, 1, DC,  5, 2, 0, 1, 1));
    vecs.push_back(mk(0, 0, 15,  2, 19, 2, 3, 1, 1, DC,  1, 2, 0, 1, 1));
    vecs.push_back(mk(0, 3, 15,  2,  1, 3, 3, 1, 2, DC, DC, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 15,  2,  8, 4, 3, 1, 2, DC, DC, 2, 2, 1, 0));
    vecs.push_back(mk(0, 0, 15,  2,  5, 4, 3, 1, 2, DC, DC, 2, 2, 1, 0));
    // Match 2: fresh start from MATCH_OVER, three draws, ignored start in FIGHT.
    vecs.push_back(mk(1, 0,  5,  5,  1, 1, 1, 0, 0,  3, DC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  5,  5, 12, 2, 1, 0, 0, DC,  5, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0,  5,  5,  4, 2, 1, 0, 0, DC,  4, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0,  5,  5, 16, 3, 1, 0, 0, DC,  0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0,  5,  5,  8, 1, 2, 0, 0,  3, DC, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0,  5,  5, 12, 2, 2, 0, 0, DC,  5, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0,  5,  5, 20, 3, 2, 0, 0, DC,  0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0,  5,  5,  8, 1, 3, 0, 0,  3, DC, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0,  5,  5, 12, 2, 3, 0, 0, DC,  5, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0,  5,  5, 20, 3, 3, 0, 0, DC,  0, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0,  5,  5,  8, 4, 3, 0, 0, DC, DC, 3, 3, 1, 0));
    vecs.push_back(mk(1, 0,  5,  5,  1, 1, 1, 0, 0,  3, DC, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output(i + 1, vecs[i]);
    end

    // Asynchronous reset in the middle of a fight.
    apply_stimulus(mk(0, 0, 15, 15, 12, 2, 1, 0, 0, DC, 5, 0, 0, 1, 1));
    check_output(100, mk(0, 0, 15, 15, 0, 2, 1, 0, 0, DC, 5, 0, 0, 1, 1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_field("async state",      101, int'(state),         0);
    check_field("async game_rst_n", 101, int'(game_rst_n),    0);
    check_field("async inputs_en",  101, int'(inputs_enable), 0);
    check_field("async round_num",  101, int'(round_num),     0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    apply_stimulus(mk(1, 0, 15, 15, 1, 1, 1, 0, 0, 3, DC, 0, 0, 0, 0));
    apply_stimulus(mk(0, 0, 15, 15, 12, 2, 1, 0, 0, DC, 5, 0, 0, 1, 1));
    check_output(110, mk(0, 0, 15, 15, 0, 2, 1, 0, 0, DC, 5, 0, 0, 1, 1));
`ifdef PAUSE_MATCH_EN
    repeat (2) @(posedge clk);
    #1;
    pause_btn = 1'b1;
    @(posedge clk);
    #1;
    check_output(111, mk(0, 0, 15, 15, 0, 5, 1, 0, 0, DC, 5, 0, 0, 1, 0));
    pause_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_output(112, mk(0, 0, 15, 15, 0, 5, 1, 0, 0, DC, 5, 0, 0, 1, 0));
    pause_btn = 1'b1;
    @(posedge clk);
    #1;
    check_output(113, mk(0, 0, 15, 15, 0, 2, 1, 0, 0, DC, 5, 0, 0, 1, 1));
    pause_btn = 1'b0;
    @(posedge clk);
    #1;
    check_output(114, mk(0, 0, 15, 15, 0, 2, 1, 0, 0, DC, 4, 0, 0, 1, 1));
`else
    pause_btn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output(111, mk(0, 0, 15, 15, 0, 2, 1, 0, 0, DC, 4, 0, 0, 1, 1));
    pause_btn = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
